// File: rtl/stream_pkg.sv
// Shared definitions for the narrow-to-wide stream packer.
package stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned MAX_RATIO          = 16;

  // Bits 0..count set; callers truncate to their own lane count.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input logic [4:0] count);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      if (5'(i) <= count) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_packer.sv
// Packs RATIO narrow words into one registered wide beat, flushing a partial
// beat early when a frame ends.
module stream_packer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned AW = RATIO - 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]                    r_count,     w_count_nxt;
  logic [AW-1:0][DATA_WIDTH-1:0]    r_acc_data,  w_acc_data_nxt;
  logic [AW-1:0]                    r_acc_keep,  w_acc_keep_nxt;
  logic                             r_out_valid, w_out_valid_nxt;
  logic [RATIO-1:0][DATA_WIDTH-1:0] r_out_data,  w_out_data_nxt;
  logic [RATIO-1:0]                 r_out_keep,  w_out_keep_nxt;
  logic                             r_out_last,  w_out_last_nxt;

  logic [RATIO-1:0][DATA_WIDTH-1:0] w_acc_ext;
  logic                             w_accept;
  logic                             w_complete;

  // A slot frees up whenever the held beat leaves this cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = (r_count == LAST_LANE) || in_last;
  assign w_acc_ext  = {{DATA_WIDTH{1'b0}}, r_acc_data};

  always_comb begin
    w_count_nxt     = r_count;
    w_acc_data_nxt  = r_acc_data;
    w_acc_keep_nxt  = r_acc_keep;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_keep_nxt  = r_out_keep;
    w_out_last_nxt  = r_out_last;

    if (r_out_valid && out_ready) w_out_valid_nxt = 1'b0;

    if (w_accept) begin
      if (w_complete) begin
        // Lanes below count come from the accumulator, lanes above are zero.
        for (int i = 0; i < RATIO; i++) begin
          if (CW'(i) == r_count)     w_out_data_nxt[i] = in_data;
          else if (CW'(i) < r_count) w_out_data_nxt[i] = w_acc_ext[i];
          else                       w_out_data_nxt[i] = '0;
        end
        w_out_keep_nxt  = {1'b0, r_acc_keep} | (RATIO'(1) << r_count);
        w_out_last_nxt  = in_last;
        w_out_valid_nxt = 1'b1;
        w_count_nxt     = '0;
        w_acc_data_nxt  = '0;
        w_acc_keep_nxt  = '0;
      end else begin
        for (int i = 0; i < AW; i++) begin
          if (CW'(i) == r_count) w_acc_data_nxt[i] = in_data;
        end
        w_acc_keep_nxt = AW'(keep_mask(5'(r_count)));
        w_count_nxt    = r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_acc_data  <= '0;
      r_acc_keep  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_acc_data  <= w_acc_data_nxt;
      r_acc_keep  <= w_acc_keep_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_keep  <= w_out_keep_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: directed test-plan steps plus random
// traffic, checked against a frame-level model of the packing rules.
module tb_stream_packer;

  localparam int unsigned DW = 32;
  localparam int unsigned R  = 4;
  localparam int unsigned OW = DW * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [R-1:0]  out_keep;
  logic          out_last;

  stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_beats = 0;

  // Model: words of the frame-in-progress plus at most one pending beat.
  logic [DW-1:0] frame[$];
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_data  = '0;
  logic [R-1:0]  m_keep  = '0;
  logic          m_last  = 1'b0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs before the edge, advance model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    logic acc;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    check("in_ready", OW'(in_ready), OW'(!m_valid || r));
    check("out_valid", OW'(out_valid), OW'(m_valid));
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_keep", OW'(out_keep), OW'(m_keep));
      check("out_last", OW'(out_last), OW'(m_last));
    end
    acc = v && (!m_valid || r);
    if (m_valid && r) begin
      m_valid = 1'b0;
      n_beats++;
    end
    if (acc) begin
      frame.push_back(d);
      if (frame.size() == R || l) begin
        m_data = '0;
        foreach (frame[i]) m_data[i*DW +: DW] = frame[i];
        m_keep  = R'((1 << frame.size()) - 1);
        m_last  = l;
        m_valid = 1'b1;
        frame.delete();
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_keep", OW'(out_keep), OW'(0));
    check("rst_out_last", OW'(out_last), OW'(0));
    frame.delete();
    m_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    #1;
    check("rst_in_ready", OW'(in_ready), OW'(1));

    // Full beat
    cycle(1, 32'h11111111, 0, 1);
    cycle(1, 32'h22222222, 0, 1);
    cycle(1, 32'h33333333, 0, 1);
    cycle(1, 32'h44444444, 1, 1);
    #1;
    check("full_data", out_data, 128'h44444444_33333333_22222222_11111111);
    check("full_keep", OW'(out_keep), OW'(4'hF));
    check("full_last", OW'(out_last), OW'(1));
    cycle(0, '0, 0, 1);

    // Partial flush
    cycle(1, 32'hA5A50001, 0, 1);
    cycle(1, 32'hDEADBEEF, 1, 1);
    #1;
    check("part_data", out_data, 128'h00000000_00000000_DEADBEEF_A5A50001);
    check("part_keep", OW'(out_keep), OW'(4'b0011));

    // Backpressure: pending beat held for 3 cycles, then released
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(1, 32'hCAFEF00D, 0, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    #1;
    check("bp_released", OW'(out_valid), OW'(0));
    check("bp_in_ready", OW'(in_ready), OW'(1));
    do_reset();

    // Simultaneous emit/complete over two back-to-back beats
    for (int i = 1; i <= 8; i++) begin
      cycle(1, DW'(i), (i == 8), 1);
      if (i == 4) begin
        #1;
        check("b2b_first_last", OW'(out_last), OW'(0));
      end
    end
    #1;
    check("b2b_second_data", out_data, 128'h00000008_00000007_00000006_00000005);
    check("b2b_second_last", OW'(out_last), OW'(1));
    cycle(0, '0, 0, 1);

    // Single-word frame
    cycle(1, 32'h12345678, 1, 1);
    #1;
    check("single_keep", OW'(out_keep), OW'(4'b0001));
    check("single_data", out_data, 128'h12345678);
    cycle(0, '0, 0, 1);

    // Reset mid-frame discards two accepted words
    cycle(1, 32'hBAD00001, 0, 1);
    cycle(1, 32'hBAD00002, 0, 1);
    do_reset();
    cycle(1, 32'h0000AAA1, 0, 1);
    cycle(1, 32'h0000AAA2, 0, 1);
    cycle(1, 32'h0000AAA3, 0, 1);
    cycle(1, 32'h0000AAA4, 0, 1);
    #1;
    check("post_rst_data", out_data, 128'h0000AAA4_0000AAA3_0000AAA2_0000AAA1);
    check("post_rst_last", OW'(out_last), OW'(0));
    cycle(0, '0, 0, 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 6));
    end
    for (int n = 0; n < 3; n++) cycle(0, '0, 0, 1);
    check("beats_seen", OW'(n_beats > 40), OW'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
